// File: rtl/fas_pkg.sv
// Shared types and helpers for the tone generator and its sine ROM.
package fas_pkg;

  localparam int SAMPLE_W = 16;
  localparam int BIN_W    = 4;
  localparam int PHASE_W  = 6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic signed [SAMPLE_W:0] SAT_MAX = 17'sd32767;
  localparam logic signed [SAMPLE_W:0] SAT_MIN = -17'sd32768;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAMPLE_W:0] x);
    if (x > SAT_MAX)
      return 16'sh7fff;
    else if (x < SAT_MIN)
      return 16'sh8000;
    else
      return x[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/fas_sine_rom.sv
// 64-point sine lookup of amplitude AMP, built from a quarter-wave table,
// with a registered output that only advances when en is high.
module fas_sine_rom
  import fas_pkg::*;
#(
  parameter int AMP = 2048
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [PHASE_W-1:0]         phase,
  output logic signed [SAMPLE_W-1:0] value
);

  // sin(k*pi/32) scaled by 1e9, rounded to the nearest sample at elaboration
  function automatic int quarter(input int k);
    longint q;
    case (k)
      0:  q = 0;
      1:  q = 98017140;
      2:  q = 195090322;
      3:  q = 290284677;
      4:  q = 382683432;
      5:  q = 471396737;
      6:  q = 555570233;
      7:  q = 634393284;
      8:  q = 707106781;
      9:  q = 773010453;
      10: q = 831469612;
      11: q = 881921264;
      12: q = 923879533;
      13: q = 956940336;
      14: q = 980785280;
      15: q = 995184727;
      16: q = 1000000000;
      default: q = 0;
    endcase
    return int'((longint'(AMP) * q + 64'sd500000000) / 64'sd1000000000);
  endfunction

  logic [14:0] qtab [17];

  for (genvar k = 0; k < 17; k++) begin : g_qtab
    localparam int QV = quarter(k);
    assign qtab[k] = 15'(QV);
  end

  logic [4:0]                 idx;
  logic [14:0]                mag;
  logic signed [SAMPLE_W-1:0] mag_s;
  logic signed [SAMPLE_W-1:0] val_c;

  // odd quadrants walk the table backwards, the lower half-cycle is negated
  assign idx   = phase[4] ? (5'd16 - {1'b0, phase[3:0]}) : {1'b0, phase[3:0]};
  assign mag   = qtab[idx];
  assign mag_s = {1'b0, mag};
  assign val_c = phase[5] ? -mag_s : mag_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value <= '0;
    else if (en)
      value <= val_c;
  end

endmodule

// File: rtl/fas_tone_gen.sv
// Burst generator of two bin-aligned quantised sinusoids, summed and
// saturated, producing the data_valid/data stream for the FAS datapath.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// RUN   | emitting samples every GAP cycles
// DONE  | one cycle after the last sample, pulses done
module fas_tone_gen
  import fas_pkg::*;
#(
  parameter int AMP         = 2048,
  parameter int NUM_SAMPLES = 1024,
  parameter int GAP         = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [BIN_W-1:0]           freq_a,
  input  logic [BIN_W-1:0]           freq_b,
  output logic                       data_valid,
  output logic signed [SAMPLE_W-1:0] data,
  output logic                       busy,
  output logic                       done
);

  localparam logic [15:0] LAST       = 16'(NUM_SAMPLES - 1);
  localparam logic [7:0]  GAP_RELOAD = 8'(GAP - 1);

  state_t                     state;
  logic [BIN_W-1:0]           fa_q;
  logic [BIN_W-1:0]           fb_q;
  logic [PHASE_W-1:0]         ph_a;
  logic [PHASE_W-1:0]         ph_b;
  logic [15:0]                n;
  logic [7:0]                 gap_cnt;
  logic                       emit;
  logic signed [SAMPLE_W-1:0] s_a;
  logic signed [SAMPLE_W-1:0] s_b;
  logic signed [SAMPLE_W:0]   sum;

  assign emit = (state == RUN) && (gap_cnt == 8'd0) && !stop;

  fas_sine_rom #(.AMP(AMP)) u_rom_a (
    .clk   (clk),
    .rst   (rst),
    .en    (emit),
    .phase (ph_a),
    .value (s_a)
  );

  fas_sine_rom #(.AMP(AMP)) u_rom_b (
    .clk   (clk),
    .rst   (rst),
    .en    (emit),
    .phase (ph_b),
    .value (s_b)
  );

  // ROM registers only load on emitted samples, so data holds between strobes
  assign sum  = {s_a[SAMPLE_W-1], s_a} + {s_b[SAMPLE_W-1], s_b};
  assign data = sat16(sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fa_q       <= '0;
      fb_q       <= '0;
      ph_a       <= '0;
      ph_b       <= '0;
      n          <= '0;
      gap_cnt    <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      data_valid <= emit;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            fa_q    <= freq_a;
            fb_q    <= freq_b;
            ph_a    <= '0;
            ph_b    <= '0;
            n       <= '0;
            gap_cnt <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (emit) begin
            ph_a    <= ph_a + {fa_q, 2'b00};
            ph_b    <= ph_b + {fb_q, 2'b00};
            n       <= n + 16'd1;
            gap_cnt <= GAP_RELOAD;
            if (n == LAST)
              state <= DONE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fas_tone_gen.sv
// Directed bench for fas_tone_gen: tone tables, saturation, pacing, abort, reset.
module tb_fas_tone_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]       st = '0;
  logic [2:0]       sp = '0;
  logic [3:0]       fa_in = '0;
  logic [3:0]       fb_in = '0;
  wire  [2:0]       dv;
  wire  [2:0]       bsy;
  wire  [2:0]       dn;
  wire  [2:0][15:0] dat;

  fas_tone_gen #(.AMP(2048), .NUM_SAMPLES(8), .GAP(1)) u_main (
    .clk(clk), .rst(rst), .start(st[0]), .stop(sp[0]), .freq_a(fa_in), .freq_b(fb_in),
    .data_valid(dv[0]), .data(dat[0]), .busy(bsy[0]), .done(dn[0]));

  fas_tone_gen #(.AMP(20000), .NUM_SAMPLES(4), .GAP(1)) u_sat (
    .clk(clk), .rst(rst), .start(st[1]), .stop(sp[1]), .freq_a(fa_in), .freq_b(fb_in),
    .data_valid(dv[1]), .data(dat[1]), .busy(bsy[1]), .done(dn[1]));

  fas_tone_gen #(.AMP(2048), .NUM_SAMPLES(4), .GAP(3)) u_gap (
    .clk(clk), .rst(rst), .start(st[2]), .stop(sp[2]), .freq_a(fa_in), .freq_b(fb_in),
    .data_valid(dv[2]), .data(dat[2]), .busy(bsy[2]), .done(dn[2]));

  typedef struct {
    logic [3:0] fa;
    logic [3:0] fb;
    int         exp [8];
  } vec_t;

  vec_t vecs [7];

  int tests = 0;
  int fails = 0;
  int got_n;
  int got_done_cyc;
  int got_data [16];
  int got_cyc  [16];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sample(input int sel);
    logic signed [15:0] v;
    v = dat[sel];
    return int'(v);
  endfunction

  task automatic start_pulse(input int sel, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    fa_in   = a;
    fb_in   = b;
    st[sel] = 1'b1;
    @(negedge clk);
    st[sel] = 1'b0;
  endtask

  // Runs one burst; optionally re-pulses start at cycle inj_cyc with freq_a=inj_fa.
  task automatic run_burst(input int sel, input logic [3:0] a, input logic [3:0] b,
                           input int inj_cyc, input logic [3:0] inj_fa, input int budget);
    got_n        = 0;
    got_done_cyc = -1;
    start_pulse(sel, a, b);
    check($sformatf("busy_after_start[%0d]", sel), int'(bsy[sel]), 1);
    for (int c = 1; c <= budget && got_done_cyc < 0; c++) begin
      @(negedge clk);
      if (dv[sel]) begin
        if (got_n < 16) begin
          got_data[got_n] = sample(sel);
          got_cyc[got_n]  = c;
        end
        got_n++;
      end
      if (dn[sel]) begin
        got_done_cyc = c;
        check($sformatf("busy_at_done[%0d]", sel), int'(bsy[sel]), 0);
      end
      st[sel] = (c == inj_cyc);
      if (c == inj_cyc) fa_in = inj_fa;
    end
    st[sel] = 1'b0;
    check($sformatf("done_seen[%0d]", sel), int'(got_done_cyc >= 0), 1);
    @(negedge clk);
    check($sformatf("done_one_cycle[%0d]", sel), int'(dn[sel]), 0);
  endtask

  task automatic check_main(input int vi);
    run_burst(0, vecs[vi].fa, vecs[vi].fb, -1, 4'd0, 40);
    check($sformatf("v%0d_count", vi), got_n, 8);
    for (int j = 0; j < 8; j++)
      check($sformatf("v%0d_s%0d", vi, j), got_data[j], vecs[vi].exp[j]);
    check($sformatf("v%0d_first_cyc", vi), got_cyc[0], 1);
    check($sformatf("v%0d_done_cyc", vi), got_done_cyc, 9);
  endtask

  task automatic wait_strobes(input int sel, input int k, input int budget);
    int cnt = 0;
    for (int c = 0; c < budget && cnt < k; c++) begin
      @(negedge clk);
      if (dv[sel]) cnt++;
    end
    check("strobe_wait", cnt, k);
  endtask

  task automatic watch_quiet(input int sel, input int ncyc, input string name);
    int seen_done = 0;
    int seen_dv   = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (dn[sel]) seen_done++;
      if (dv[sel]) seen_dv++;
    end
    check({name, "_no_done"}, seen_done, 0);
    check({name, "_no_valid"}, seen_dv, 0);
  endtask

  initial begin
    vecs[0] = '{fa: 4'd4,  fb: 4'd0,  exp: '{0, 2048, 0, -2048, 0, 2048, 0, -2048}};
    vecs[1] = '{fa: 4'd2,  fb: 4'd0,  exp: '{0, 1448, 2048, 1448, 0, -1448, -2048, -1448}};
    vecs[2] = '{fa: 4'd8,  fb: 4'd0,  exp: '{0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[3] = '{fa: 4'd4,  fb: 4'd4,  exp: '{0, 4096, 0, -4096, 0, 4096, 0, -4096}};
    vecs[4] = '{fa: 4'd1,  fb: 4'd0,  exp: '{0, 784, 1448, 1892, 2048, 1892, 1448, 784}};
    vecs[5] = '{fa: 4'd15, fb: 4'd0,  exp: '{0, -784, -1448, -1892, -2048, -1892, -1448, -784}};
    vecs[6] = '{fa: 4'd4,  fb: 4'd12, exp: '{0, 0, 0, 0, 0, 0, 0, 0}};

    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_valid[%0d]", s), int'(dv[s]), 0);
      check($sformatf("rst_data[%0d]", s), sample(s), 0);
      check($sformatf("rst_busy[%0d]", s), int'(bsy[s]), 0);
      check($sformatf("rst_done[%0d]", s), int'(dn[s]), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      check_main(i);

    // saturation: AMP=20000, both tones in bin 4
    run_burst(1, 4'd4, 4'd4, -1, 4'd0, 40);
    check("sat_count", got_n, 4);
    check("sat_s0", got_data[0], 0);
    check("sat_s1", got_data[1], 32767);
    check("sat_s2", got_data[2], 0);
    check("sat_s3", got_data[3], -32768);
    check("sat_done_cyc", got_done_cyc, 5);

    // pacing with GAP=3 and an ignored start at t+5 carrying a new frequency
    run_burst(2, 4'd2, 4'd0, 4, 4'd4, 40);
    check("gap_count", got_n, 4);
    for (int j = 0; j < 4; j++)
      check($sformatf("gap_cyc%0d", j), got_cyc[j], 1 + 3 * j);
    check("gap_s0", got_data[0], 0);
    check("gap_s1", got_data[1], 1448);
    check("gap_s2", got_data[2], 2048);
    check("gap_s3", got_data[3], 1448);
    check("gap_done_cyc", got_done_cyc, 11);
    watch_quiet(2, 10, "gap_after");

    // stop during the 3rd strobe cycle
    start_pulse(0, 4'd2, 4'd0);
    wait_strobes(0, 3, 20);
    check("stop_pre_data", sample(0), 2048);
    sp[0] = 1'b1;
    @(negedge clk);
    sp[0] = 1'b0;
    check("stop_valid", int'(dv[0]), 0);
    check("stop_busy", int'(bsy[0]), 0);
    check("stop_data_hold", sample(0), 2048);
    watch_quiet(0, 12, "stop");
    check_main(1);

    // reset in the middle of a burst
    start_pulse(0, 4'd2, 4'd0);
    wait_strobes(0, 3, 20);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", int'(dv[0]), 0);
    check("rst_mid_busy", int'(bsy[0]), 0);
    check("rst_mid_data", sample(0), 0);
    @(negedge clk);
    rst = 1'b0;
    watch_quiet(0, 12, "rst_mid");
    check_main(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fas_tone_gen.md
# fas_tone_gen

Synthetic stimulus source for the frequency-analysis datapath. It drives the sample stream that the FIR stage consumes. On a start pulse it emits a fixed-length burst of 16-bit signed samples formed from two quantised sinusoids. Each sinusoid sits exactly on one of the 16 FFT bins, so the analyser's reported peak bin is known in advance. It sits in front of the FAS top, in the bench or on-chip BIST path, and produces the same `data_valid`/`data` pair the FAS top expects.

## Interface
- `AMP`, 2048: peak amplitude of each tone, unsigned, 1..32767.
- `NUM_SAMPLES`, 1024: samples per burst, 1..65535.
- `GAP`, 1: cycles between consecutive valid samples; 1 means back-to-back; 1..255.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a burst; honoured only in IDLE.
- `stop`  in  1  synchronous abort; returns to IDLE the next cycle.
- `freq_a`  in  4  bin index of tone A; latched at accepted start.
- `freq_b`  in  4  bin index of tone B; latched at accepted start.
- `data_valid`  out  1  sample strobe, one cycle per sample.
- `data`  out  16  signed two's-complement sample; held between strobes.
- `busy`  out  1  high from the accepted start through the last sample.
- `done`  out  1  one-cycle pulse after the final sample of a completed burst.

## Operation
- **States.**
  - IDLE: `start` goes to RUN and latches `freq_a`/`freq_b`; sample counter n=0 and gap counter cleared.
  - RUN: when n = NUM_SAMPLES-1 is emitted, go to DONE.
  - DONE: goes to IDLE unconditionally after one cycle.
- **Phase.** 6-bit index into a 64-point sine: `ph_x = (n * 4 * freq_x) mod 64`.
  - Implemented as two 6-bit accumulators, each stepping by `{freq_x,2'b00}` per emitted sample and wrapping naturally.
- **Sine value.** `s(p) = round(AMP * sin(2*pi*p/64))`.
  - Generated from a 17-entry quarter-wave table (p = 0..16) plus quadrant mirroring and negation.
  - s(0)=s(32)=0, s(16)=AMP, s(48)=-AMP.
- **Sample.** `data = sat16(s(ph_a) + s(ph_b))`.
  - Sum is computed at 17 bits and saturated to +32767 / -32768.
- **Bin 0.** freq=0 gives a constant-zero tone, not DC. Using `freq_a=freq_b` doubles the amplitude.
- **Start while busy.** `start` while `busy` is ignored; latched frequencies do not change mid-burst.
- **Stop.** `stop` in RUN goes to IDLE:
  - no `done`;
  - `data_valid` low from the next cycle;
  - `data` holds its last value.
  - `stop` has priority over `start` in the same cycle. `stop` in IDLE/DONE has no effect.
- **Reset.** Every output resets to 0: `data_valid=0`, `data=16'h0000`, `busy=0`, `done=0`. State resets to IDLE and all counters/accumulators clear. Asserting `rst` mid-burst discards the burst.

## Timing
- **First sample.** `start` sampled high in IDLE at edge t gives `busy`=1 from t. The first `data_valid` is at edge t+1 with n=0, and `data` is always 0 for n=0.
- **Pacing.** Sample k is valid at edge t+1+k*GAP. `data_valid` is a single-cycle pulse for every GAP value.
- **Registered outputs.** `data` and `data_valid` are updated together on the same edge. The ROM lookup is registered: total latency from accumulator update to `data` is 1 cycle, and this is absorbed in the t+1 figure above.
- **Burst end.** The last sample is at edge t+1+(NUM_SAMPLES-1)*GAP.
  - Next edge: `busy`=0, `done`=1 for one cycle.
  - IDLE follows; a new `start` is accepted one edge after `done` goes high.
- **Abort.** `stop` at edge s gives `busy`=0 at s+1.

## Structure
- Shared package `fas_pkg`:
  - `SAMPLE_W`=16;
  - `BIN_W`=4;
  - `PHASE_W`=6;
  - state enum {IDLE, RUN, DONE};
  - `sat16` function.
- Sub-module `fas_sine_rom`: 6-bit phase in, 16-bit signed value out. It contains the quarter-wave table computed from `AMP` at elaboration, the mirroring logic, and the output register. It is instantiated twice, one per tone.

## Test plan
- **Single tone, bin 4.** AMP=2048, freq_a=4, freq_b=0, GAP=1, NUM_SAMPLES=8.
  - `data` = 0, 2048, 0, -2048, 0, 2048, 0, -2048 on consecutive cycles.
  - `done` one cycle after the 8th strobe.
- **Bin 2.** freq_a=2, freq_b=0.
  - First five samples are 0, 1448, 2048, 1448, 0, then -1448.
- **Bin 8.** freq_a=8.
  - All samples are 0.
  - Downstream FAS with NUM_SAMPLES=1024 and freq_a=3 reports `freq`=3.
- **Saturation.** AMP=20000, freq_a=freq_b=4.
  - Samples are 0, 32767, 0, -32768.
- **Pacing and overlap.** GAP=3, NUM_SAMPLES=4.
  - Strobes at t+1, t+4, t+7, t+10; `done` at t+11.
  - A second `start` at t+5 is ignored: no frequency change and no extra samples.
- **Abort and reset.** `stop` at the 3rd strobe cycle, then `rst` mid-burst on a rerun.
  - Both cases: `data_valid`/`busy` low next cycle and no `done`.
  - After reset: `data`=0.
  - A new `start` after each abort produces a full, correct burst beginning at 0.
